// File: rtl/chord_player.sv
// chord_player: latches three-voice chords, counts voice durations down on beat, reports chord completion
module chord_player #(
  parameter int NOTE_WIDTH = 6,
  parameter int DURATION_WIDTH = 6,
  parameter int VOICES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic play,
  input  logic beat,
  input  logic new_note,
  input  logic [VOICES*NOTE_WIDTH-1:0] notes_in,
  input  logic [VOICES*DURATION_WIDTH-1:0] durations_in,
  output logic [VOICES*NOTE_WIDTH-1:0] voice_note,
  output logic [VOICES-1:0] voice_active,
  output logic [VOICES-1:0] voice_load,
  output logic note_done
);
  typedef enum logic {IDLE, PLAYING} state_t;
  state_t state, state_nx;
  logic [NOTE_WIDTH-1:0] note_r [VOICES];
  logic [DURATION_WIDTH-1:0] cnt [VOICES];
  logic [VOICES-1:0] cnt_nz, load_mask;
  logic all_zero, done_nx, tick;
  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    assign cnt_nz[v] = cnt[v] != '0;
    assign voice_active[v] = cnt_nz[v] && note_r[v] != '0;
    assign voice_note[v*NOTE_WIDTH +: NOTE_WIDTH] = voice_active[v] ? note_r[v] : '0;
    assign load_mask[v] = notes_in[v*NOTE_WIDTH +: NOTE_WIDTH] != '0
                       && durations_in[v*DURATION_WIDTH +: DURATION_WIDTH] != '0;
  end
  always_comb begin
    all_zero = ~|cnt_nz;
    state_nx = new_note ? PLAYING : (state == PLAYING && all_zero) ? IDLE : state;
    done_nx = !new_note && state == PLAYING && all_zero;
    tick = beat && play && !new_note && state == PLAYING;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      note_done <= 1'b0;
      voice_load <= '0;
      for (int i = 0; i < VOICES; i++) begin
        note_r[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      state <= state_nx;
      note_done <= done_nx;
      voice_load <= new_note ? load_mask : '0;
      for (int i = 0; i < VOICES; i++) begin
        if (new_note) begin
          note_r[i] <= notes_in[i*NOTE_WIDTH +: NOTE_WIDTH];
          cnt[i] <= durations_in[i*DURATION_WIDTH +: DURATION_WIDTH];
        end else if (tick && cnt_nz[i]) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_chord_player.sv
// tb_chord_player: directed and random stimulus checked against a per-voice beat-budget model
module tb_chord_player;
  logic clk = 1'b0;
  logic reset = 1'b1, play = 1'b0, beat = 1'b0, new_note = 1'b0;
  logic [17:0] notes_in = '0, durations_in = '0;
  logic [17:0] voice_note;
  logic [2:0] voice_active, voice_load;
  logic note_done;
  int checks = 0, failures = 0, done_seen = 0;
  int rem [3], nt [3];
  bit playing = 0, exp_done = 0;
  logic [2:0] exp_load = '0;

  chord_player dut (
    .clk(clk), .reset(reset), .play(play), .beat(beat), .new_note(new_note),
    .notes_in(notes_in), .durations_in(durations_in), .voice_note(voice_note),
    .voice_active(voice_active), .voice_load(voice_load), .note_done(note_done)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pack3(int a, int b, int c);
    return {6'(a), 6'(b), 6'(c)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // voice v lives in field (2-v) of every packed bus
  task automatic model(bit rs, bit pl, bit bt, bit nn, logic [17:0] n, logic [17:0] d);
    logic [17:0] nf, df;
    nf = n;
    df = d;
    if (rs) begin
      playing = 0; exp_done = 0; exp_load = '0;
      for (int v = 0; v < 3; v++) begin rem[v] = 0; nt[v] = 0; end
    end else begin
      exp_done = 0; exp_load = '0;
      if (nn) begin
        playing = 1;
        for (int v = 0; v < 3; v++) begin
          nt[v] = int'(nf[(2-v)*6 +: 6]);
          rem[v] = int'(df[(2-v)*6 +: 6]);
          exp_load[2-v] = nt[v] != 0 && rem[v] != 0;
        end
      end else if (playing) begin
        if (rem[0] + rem[1] + rem[2] == 0) begin
          playing = 0;
          exp_done = 1;
        end else if (bt && pl) begin
          for (int v = 0; v < 3; v++) if (rem[v] > 0) rem[v] = rem[v] - 1;
        end
      end
    end
  endtask

  task automatic step(bit rs, bit pl, bit bt, bit nn, logic [17:0] n, logic [17:0] d);
    logic [17:0] en;
    logic [2:0] ea;
    reset = rs; play = pl; beat = bt; new_note = nn; notes_in = n; durations_in = d;
    @(posedge clk);
    model(rs, pl, bt, nn, n, d);
    #1;
    en = '0;
    ea = '0;
    for (int v = 0; v < 3; v++) begin
      ea[2-v] = rem[v] > 0 && nt[v] != 0;
      en[(2-v)*6 +: 6] = ea[2-v] ? 6'(nt[v]) : 6'd0;
    end
    chk("voice_note", 32'(voice_note), 32'(en));
    chk("voice_active", 32'(voice_active), 32'(ea));
    chk("voice_load", 32'(voice_load), 32'(exp_load));
    chk("note_done", 32'(note_done), 32'(exp_done));
    if (note_done === 1'b1) done_seen++;
  endtask

  task automatic idle(int k, bit pl);
    for (int i = 0; i < k; i++) step(0, pl, 0, 0, '0, '0);
  endtask

  initial begin
    step(1, 0, 0, 0, '0, '0);
    step(1, 1, 1, 0, '0, '0);
    chk("reset_note", 32'(voice_note), 32'd0);
    idle(3, 1);
    // basic chord
    done_seen = 0;
    step(0, 1, 0, 1, pack3(10, 20, 30), pack3(2, 4, 4));
    chk("basic_load", 32'(voice_load), 32'b111);
    chk("basic_note", 32'(voice_note), 32'(pack3(10, 20, 30)));
    for (int b = 0; b < 4; b++) begin idle(7, 1); step(0, 1, 1, 0, '0, '0); end
    idle(4, 1);
    chk("basic_done_count", 32'(done_seen), 32'd1);
    // rest voices
    done_seen = 0;
    step(0, 1, 0, 1, pack3(0, 5, 0), pack3(3, 1, 0));
    chk("rest_load", 32'(voice_load), 32'b010);
    for (int b = 0; b < 3; b++) begin idle(3, 1); step(0, 1, 1, 0, '0, '0); end
    idle(3, 1);
    chk("rest_done_count", 32'(done_seen), 32'd1);
    // pause
    done_seen = 0;
    step(0, 1, 0, 1, pack3(7, 8, 9), pack3(2, 2, 2));
    idle(2, 1);
    step(0, 1, 1, 0, '0, '0);
    for (int b = 0; b < 5; b++) begin idle(2, 0); step(0, 0, 1, 0, '0, '0); end
    chk("pause_no_done", 32'(done_seen), 32'd0);
    chk("pause_active", 32'(voice_active), 32'b111);
    step(0, 1, 1, 0, '0, '0);
    idle(3, 1);
    chk("pause_done_count", 32'(done_seen), 32'd1);
    // collisions: beat with new_note, then overwrite mid-chord
    done_seen = 0;
    step(0, 1, 1, 1, pack3(1, 2, 3), pack3(1, 1, 1));
    idle(2, 1);
    chk("collide_active", 32'(voice_active), 32'b111);
    step(0, 1, 0, 1, pack3(4, 0, 6), pack3(2, 3, 0));
    step(0, 1, 1, 0, '0, '0);
    chk("overwrite_no_done", 32'(done_seen), 32'd0);
    // reset mid-chord then beats
    step(1, 1, 0, 0, '0, '0);
    chk("reset_active", 32'(voice_active), 32'd0);
    for (int b = 0; b < 4; b++) step(0, 1, 1, 0, '0, '0);
    chk("reset_no_done", 32'(done_seen), 32'd0);
    // all-zero durations
    step(0, 1, 0, 1, pack3(3, 3, 3), pack3(0, 0, 0));
    step(0, 1, 0, 0, '0, '0);
    chk("zero_done", 32'(note_done), 32'd1);
    idle(2, 1);
    // random phase
    for (int i = 0; i < 1500; i++)
      step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom_range(2) == 0,
           $urandom_range(11) == 0,
           pack3($urandom_range(3) == 0 ? 0 : $urandom_range(63), $urandom_range(63), $urandom_range(63)),
           pack3($urandom_range(5), $urandom_range(5), $urandom_range(5)));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chord_player.md
# chord_player

Plays chords delivered by the song reader. On each `new_note` pulse it latches a three-voice chord (note codes plus per-voice durations) and counts each voice's duration down on `beat` while `play` is high. It drives per-voice note codes and enables to the note-to-frequency and sine-generation stages. Once every voice has expired it reports `note_done` back to the song reader.

## Interface
Parameters
- `NOTE_WIDTH`, 6: width of one note code; code 0 is a rest.
- `DURATION_WIDTH`, 6: width of one duration in beats.
- `VOICES`, 3: number of voices; fixed at 3 in this revision.

Ports
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `play`  in  1  high = run; low = pause and freeze all counters.
- `beat`  in  1  one-cycle tick; each pulse counts as one beat.
- `new_note`  in  1  one-cycle strobe: `notes_in`/`durations_in` are valid.
- `notes_in`  in  18  `{voice0, voice1, voice2}`; voice0 occupies bits [17:12].
- `durations_in`  in  18  `{dur0, dur1, dur2}`; same packing as `notes_in`.
- `voice_note`  out  18  currently sounding note code per voice, same packing; 0 when the voice is idle.
- `voice_active`  out  3  bit i = voice i is sounding (bit 2 = voice0).
- `voice_load`  out  3  one-cycle pulse: voice i has just loaded a new nonzero note (frequency lookup restarts).
- `note_done`  out  1  one-cycle pulse: the chord has fully expired.

## Operation
- FSM states: IDLE (the reset state) and PLAYING.
- Per voice i, registers `note_r[i]` (6 bits) and `cnt[i]` (6 bits). `voice_active[i] = (cnt[i] != 0) && (note_r[i] != 0)`. `voice_note[i] = voice_active[i] ? note_r[i] : 0`.
- Load on `new_note` in any state, regardless of `play`:
  - `note_r[i] <= notes_in[i]` and `cnt[i] <= durations_in[i]`.
  - FSM goes to PLAYING.
  - `voice_load[i] <= (notes_in[i] != 0) && (durations_in[i] != 0)`.
- Countdown: on `beat && play && !new_note`, each `cnt[i] != 0` decrements by 1. Counters never wrap below 0.
- Rest voice (note 0) still counts its duration but is never active. The chord ends when all `cnt` are 0.
- PLAYING with all `cnt == 0` and no `new_note`:
  - FSM goes to IDLE.
  - `note_done` is 1 for exactly that next cycle, then 0.
- Pause (`play` = 0): counters hold, `voice_note` and `voice_active` hold, no `note_done` is generated.
- Priority: `reset` > `new_note` > `beat`. A `beat` coinciding with `new_note` is dropped and is not applied to the new chord.
- A `new_note` arriving while a chord is still sounding overwrites all voices immediately. No `note_done` is emitted for the abandoned chord.
- `reset`: all `note_r`, `cnt`, `voice_note`, `voice_active`, `voice_load`, `note_done` become 0; FSM goes to IDLE. This applies mid-chord as well; in-flight state is discarded.

## Timing
- All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.
- `new_note` sampled at edge N:
  - `voice_note`/`voice_active` are valid after N.
  - `voice_load` is high for the cycle after N only.
- Duration D ≥ 1 with `play` held high: the voice stays active across exactly D sampled beats. It drops at the edge that samples the D-th beat.
- Duration 0: the voice is never active. A chord of all-zero durations gives `note_done` high in the second cycle after `new_note`: one cycle in PLAYING, then the IDLE-transition pulse.
- `note_done` is high in the cycle following the first cycle in which PLAYING sees all counters at 0. It is never asserted in IDLE without a prior PLAYING.
- In IDLE, `beat` and `play` have no effect.

## Test plan
- Basic chord: `play`=1; `new_note` with notes {10, 20, 30} and durations {2, 4, 4}; 4 beats 8 cycles apart. Required: `voice_load`=111 for 1 cycle, `voice_note`=`{10,20,30}`; voice0 drops after beat 2; voices 1 and 2 drop after beat 4; `note_done` pulses once, 1 cycle later.
- Rest voice: notes {0, 5, 0}, durations {3, 1, 0}. Required: `voice_load`=010, `voice_active`=010 until beat 1, then 000. `note_done` fires only after beat 3.
- Pause: durations {2, 2, 2}; after beat 1 drop `play` and issue 5 beats. Required: counters stay at 1 and no `note_done`. Raise `play`, then 1 beat → `note_done`.
- Collisions: `new_note` in the same cycle as `beat` leaves counters at their loaded values. `new_note` mid-chord replaces the voices with no `note_done` pulse for the old chord.
- Reset mid-chord, and the zero case: with voices active, assert `reset` for 1 cycle → all outputs 0 and FSM in IDLE; subsequent beats produce no `note_done`. All-zero durations → `note_done` 2 cycles after `new_note`.
